rf_writeback: RTL and testbench
===============================

// Module: rf_writeback
// PURPOSE
//  Write-side driver for the 32x32b register file: merges ALU results (single-cycle, no backpressure) and
//  load returns from the LSU (valid/ready) into the single write port (addr_rd/data_rd/write_enable).
//  Formats load data (LB/LH/LW/LBU/LHU) and keeps a pending-load scoreboard that issue logic queries to stall on RAW hazards.
// PARAMETERS
//  DEPTH  2   load-return FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high reset
//  alu_valid     in   1   ALU result valid this cycle; always accepted
//  alu_rd        in   5   ALU destination register
//  alu_data      in   32  ALU result
//  lsu_valid     in   1   load return valid
//  lsu_ready     out  1   FIFO can accept a load return
//  lsu_rd        in   5   load destination register
//  lsu_funct3    in   3   load type (RV32I funct3)
//  lsu_offset    in   2   byte offset (addr[1:0])
//  lsu_rdata     in   32  raw aligned memory word
//  issue_valid   in   1   a load is issued to the LSU this cycle
//  issue_rd      in   5   destination of the issued load
//  query_rs1     in   5   scoreboard lookup index 1
//  query_rs2     in   5   scoreboard lookup index 2
//  busy_rs1      out  1   pending[query_rs1], combinational
//  busy_rs2      out  1   pending[query_rs2], combinational
//  addr_rd       out  5   regfile write address (registered)
//  data_rd       out  32  regfile write data (registered)
//  write_enable  out  1   regfile write strobe (registered)
//  fifo_count    out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: write_enable=0, addr_rd=0, data_rd=0, pending[31:0]=0, FIFO empty (fifo_count=0); in-flight data discarded.
//  lsu_ready = !reset && fifo_count<DEPTH; no pass-through when full, even if dequeuing the same cycle.
//  Enqueue on lsu_valid&&lsu_ready: store {lsu_rd, formatted data}; lsu_rd==0 entries are dropped, not enqueued.
//  Formatting (byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]; off[0] ignored for halves):
//   000 LB sext byte; 001 LH sext half; 010 LW word; 100 LBU zext byte; 101 LHU zext half; other: word unmodified.
//  Output stage, every posedge (priority order):
//   1. alu_valid && alu_rd!=0: load ALU {rd,data}, write_enable=1, is_load=0.
//   2. else FIFO non-empty: pop head, write_enable=1, is_load=1.
//   3. else write_enable=0 (addr_rd/data_rd hold).
//   ALU with rd==0 produces no write and does not block the FIFO.
//  Latency: ALU sampled at edge N -> write_enable high N..N+1 -> regfile writes at edge N+1.
//   Load accepted at edge N -> output at N+1 (if no ALU) -> regfile writes at N+2. Strict FIFO order among loads.
//  Scoreboard: issue_valid && issue_rd!=0 sets pending[issue_rd]. Cleared on the edge where
//   write_enable&&is_load (same edge the regfile captures the data). Set and clear on the same index
//   at the same edge: set wins. pending[0] is always 0; busy for query 0 is always 0.
//  Upstream contract (not checked): never issue a second load or any ALU op to a register whose pending bit is set.
//  Simultaneous enqueue and dequeue with FIFO non-full: both occur; count unchanged.
//  Pointers wrap modulo DEPTH; count saturates never (guarded by lsu_ready).
// TESTING
//  1. reset; alu_valid rd=5 data=0xDEADBEEF one cycle -> next cycle write_enable=1, addr_rd=5, data_rd=0xDEADBEEF, then 0.
//  2. issue rd=7; query_rs1=7 -> busy_rs1=1; LSU LB off=2 rdata=0x0080_0000 -> data_rd=0xFFFFFF80 2 cycles later; busy_rs1=0 after write edge.
//  3. ALU rd=3 and LSU LHU rd=4 off=2 rdata=0xBEEF_0000 same cycle -> rd3 written first, rd4=0x0000BEEF next cycle;
//     ALU valid 3 cycles with 2 loads queued -> lsu_ready=0, fifo_count=2 until ALU idles.
//  4. ALU rd=0 and LSU rd=0; issue_rd=0 -> write_enable never 1, busy for query 0 stays 0, fifo_count stays 0.
//  5. Load to rd=9 writing back on same edge as new issue rd=9 -> pending[9] remains 1.
//  6. Two loads queued, pending set, reset asserted one cycle -> fifo_count=0, busy=0, no writes after reset.

Source files
------------

// File: rtl/rf_writeback.sv
// Register-file write-port driver: merges single-cycle ALU results with LSU load returns
// through a small FIFO, formats load data, and tracks pending loads for RAW stalls.
module rf_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [2:0]               lsu_funct3,
  input  logic [1:0]               lsu_offset,
  input  logic [31:0]              lsu_rdata,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               query_rs1,
  input  logic [4:0]               query_rs2,
  output logic                     busy_rs1,
  output logic                     busy_rs2,
  output logic [4:0]               addr_rd,
  output logic [31:0]              data_rd,
  output logic                     write_enable,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  function automatic logic [31:0] fmt_load(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] w);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = off[1] ? w[31:16] : w[15:0];
    sb = b;
    sh = h;
    case (f)
      3'b000:  fmt_load = 32'(sb);
      3'b001:  fmt_load = 32'(sh);
      3'b100:  fmt_load = 32'(b);
      3'b101:  fmt_load = 32'(h);
      default: fmt_load = w;
    endcase
  endfunction

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          r_we_p1;
  logic          r_is_load_p1;
  logic [4:0]    r_addr_p1;
  logic [31:0]   r_data_p1;
  logic [31:0]   r_pending;
  logic [31:0]   w_pend_nxt;

  logic          w_alu_wr;
  logic          w_enq;
  logic          w_deq;

  assign lsu_ready = !reset && (r_count < CNT_FULL);
  assign w_alu_wr  = alu_valid && (alu_rd != 5'd0);
  assign w_enq     = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign w_deq     = !w_alu_wr && (r_count != '0);

  // Stage p0: load-return FIFO (formatted on entry)
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_rd[r_wptr]   <= lsu_rd;
      r_fifo_data[r_wptr] <= fmt_load(lsu_funct3, lsu_offset, lsu_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage p1: registered write port; ALU has priority over queued loads
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we_p1      <= 1'b0;
      r_is_load_p1 <= 1'b0;
      r_addr_p1    <= '0;
      r_data_p1    <= '0;
    end else if (w_alu_wr) begin
      r_we_p1      <= 1'b1;
      r_is_load_p1 <= 1'b0;
      r_addr_p1    <= alu_rd;
      r_data_p1    <= alu_data;
    end else if (w_deq) begin
      r_we_p1      <= 1'b1;
      r_is_load_p1 <= 1'b1;
      r_addr_p1    <= r_fifo_rd[r_rptr];
      r_data_p1    <= r_fifo_data[r_rptr];
    end else begin
      r_we_p1      <= 1'b0;
      r_is_load_p1 <= 1'b0;
    end
  end

  // Clear lands on the regfile capture edge; a same-index issue overrides it
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_we_p1 && r_is_load_p1) w_pend_nxt[r_addr_p1] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) w_pend_nxt[issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pend_nxt;
  end

  assign busy_rs1     = (query_rs1 != 5'd0) && r_pending[query_rs1];
  assign busy_rs2     = (query_rs2 != 5'd0) && r_pending[query_rs2];
  assign addr_rd      = r_addr_p1;
  assign data_rd      = r_data_p1;
  assign write_enable = r_we_p1;
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios then random traffic, all checked against
// a queue/array reference model of the write-back rules.
module tb_rf_writeback;
  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_offset;
  logic [31:0] lsu_rdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        write_enable;
  logic [$clog2(DEPTH):0] fifo_count;

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset), .lsu_rdata(lsu_rdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .addr_rd(addr_rd), .data_rd(data_rd), .write_enable(write_enable),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend[32];
  bit          m_we;
  bit          m_isl;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          n_chk;
  int          n_err;

  function automatic logic [31:0] ref_fmt(logic [2:0] f, logic [1:0] off, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0; m_isl = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic idle();
    reset = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_funct3 = '0; lsu_offset = '0; lsu_rdata = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers after it.
  task automatic cyc();
    bit   rdy;
    ent_t e;
    #1;
    rdy = !reset && (mq.size() < DEPTH);
    chk("lsu_ready", 32'(lsu_ready), 32'(rdy));
    chk("busy_rs1", 32'(busy_rs1), 32'(query_rs1 != 0 && m_pend[query_rs1]));
    chk("busy_rs2", 32'(busy_rs2), 32'(query_rs2 != 0 && m_pend[query_rs2]));
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (m_we && m_isl) m_pend[m_addr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (alu_valid && alu_rd != 0) begin
        m_we = 1'b1; m_isl = 1'b0; m_addr = alu_rd; m_data = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_isl = 1'b1; m_addr = e.rd; m_data = e.data;
      end else begin
        m_we = 1'b0; m_isl = 1'b0;
      end
      if (lsu_valid && rdy && lsu_rd != 0) begin
        e.rd = lsu_rd;
        e.data = ref_fmt(lsu_funct3, lsu_offset, lsu_rdata);
        mq.push_back(e);
      end
    end
    #1;
    chk("write_enable", 32'(write_enable), 32'(m_we));
    chk("addr_rd", 32'(addr_rd), 32'(m_addr));
    chk("data_rd", data_rd, m_data);
    chk("fifo_count", 32'(fifo_count), mq.size());
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    idle();
    query_rs1 = '0; query_rs2 = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cyc();
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);

    // 1: single ALU write
    idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cyc();
    chk("t1_we", 32'(write_enable), 32'd1);
    chk("t1_addr", 32'(addr_rd), 32'd5);
    chk("t1_data", data_rd, 32'hDEADBEEF);
    idle(); cyc();
    chk("t1_we_low", 32'(write_enable), 32'd0);

    // 2: issued load, LB sign-extension, scoreboard clear
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; query_rs1 = 5'd7;
    cyc();
    chk("t2_busy_set", 32'(busy_rs1), 32'd1);
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_funct3 = 3'b000; lsu_offset = 2'd2;
    lsu_rdata = 32'h0080_0000;
    cyc();
    idle(); cyc();
    chk("t2_we", 32'(write_enable), 32'd1);
    chk("t2_lb", data_rd, 32'hFFFFFF80);
    chk("t2_busy_hold", 32'(busy_rs1), 32'd1);
    cyc();
    chk("t2_busy_clr", 32'(busy_rs1), 32'd0);

    // 3: ALU and load in the same cycle, then ALU holding off two queued loads
    idle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1111_2222;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_funct3 = 3'b101; lsu_offset = 2'd2; lsu_rdata = 32'hBEEF_0000;
    cyc();
    chk("t3_alu_first", 32'(addr_rd), 32'd3);
    idle(); cyc();
    chk("t3_load_addr", 32'(addr_rd), 32'd4);
    chk("t3_lhu", data_rd, 32'h0000BEEF);
    for (int i = 0; i < 3; i++) begin
      idle(); alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = $urandom;
      lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_funct3 = 3'b010; lsu_rdata = $urandom;
      cyc();
    end
    chk("t3_full_count", 32'(fifo_count), 32'd2);
    chk("t3_not_ready", 32'(lsu_ready), 32'd0);
    idle();
    for (int i = 0; i < 3; i++) cyc();

    // 4: everything aimed at x0
    idle(); alu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b1;
    alu_data = 32'h1234_5678; lsu_rdata = 32'hFFFF_FFFF; query_rs1 = '0; query_rs2 = '0;
    cyc();
    chk("t4_we", 32'(write_enable), 32'd0);
    chk("t4_count", 32'(fifo_count), 32'd0);
    idle(); cyc();
    chk("t4_busy0", 32'(busy_rs1), 32'd0);

    // 5: re-issue to rd9 on the edge its previous load writes back
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; query_rs2 = 5'd9;
    cyc();
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = 3'b010; lsu_rdata = 32'hCAFE_F00D;
    cyc();
    idle(); cyc();
    chk("t5_we_load", 32'(write_enable), 32'd1);
    idle(); issue_valid = 1'b1; issue_rd = 5'd9;
    cyc();
    chk("t5_set_wins", 32'(busy_rs2), 32'd1);

    // 6: reset with two loads queued and pending bits set
    idle(); issue_valid = 1'b1; issue_rd = 5'd12; query_rs1 = 5'd12; query_rs2 = 5'd13;
    cyc();
    idle(); issue_valid = 1'b1; issue_rd = 5'd13;
    cyc();
    for (int i = 0; i < 2; i++) begin
      idle(); alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = $urandom;
      lsu_valid = 1'b1; lsu_rd = 5'(12 + i); lsu_funct3 = 3'b001; lsu_offset = 2'(i * 2);
      lsu_rdata = $urandom;
      cyc();
    end
    chk("t6_queued", 32'(fifo_count), 32'd2);
    idle(); reset = 1'b1;
    cyc();
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_busy1", 32'(busy_rs1), 32'd0);
    chk("t6_busy2", 32'(busy_rs2), 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_write", 32'(write_enable), 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      reset       = ($urandom_range(0, 63) == 0);
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 1) == 1);
      lsu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lsu_funct3  = 3'($urandom);
      lsu_offset  = 2'($urandom);
      lsu_rdata   = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom);
      query_rs1   = 5'($urandom_range(0, 7));
      query_rs2   = 5'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
